// File: rtl/nic_slave_mem.sv
// Word-addressed RAM slave for the nic interconnect with WAIT_STATES wait cycles before each ack.
// Optional macro NIC_SLAVE_MEM_CLEAR_EN zero-fills the whole memory after every reset release.
module nic_slave_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int WAIT_STATES = 0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_sel,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic                    i_wr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_ack,
    output logic                    o_busy
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = 5;
    localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] WS_B2B  = CNT_W'(WAIT_STATES + 1);

`ifdef NIC_SLAVE_MEM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_CLEAR} state_t;
    localparam state_t RESET_STATE = S_CLEAR;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  acc_en;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_wr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [STRB_W-1:0]     acc_wstrb;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        acc_en    = 1'b0;
        acc_addr  = addr_q;
        acc_wr    = wr_q;
        acc_wdata = wdata_q;
        acc_wstrb = wstrb_q;
`ifdef NIC_SLAVE_MEM_CLEAR_EN
        clr_we     = 1'b0;
        clr_addr_d = clr_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_sel) begin
                    addr_d  = i_addr;
                    wr_d    = i_wr;
                    wdata_d = i_wdata;
                    wstrb_d = i_wstrb;
                    cnt_d   = WS_LOAD;
                    if (WAIT_STATES == 0) begin
                        acc_en    = 1'b1;
                        acc_addr  = i_addr;
                        acc_wr    = i_wr;
                        acc_wdata = i_wdata;
                        acc_wstrb = i_wstrb;
                        state_d   = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!i_sel) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    acc_en  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                // A request held across ACK is captured now but served after one
                // turnaround cycle, so acks stay single-cycle pulses.
                if (i_sel) begin
                    addr_d  = i_addr;
                    wr_d    = i_wr;
                    wdata_d = i_wdata;
                    wstrb_d = i_wstrb;
                    cnt_d   = WS_B2B;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef NIC_SLAVE_MEM_CLEAR_EN
            S_CLEAR: begin
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        rdata_d = (acc_en && !acc_wr) ? mem[acc_addr] : rdata_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            rdata_q    <= '0;
`ifdef NIC_SLAVE_MEM_CLEAR_EN
            clr_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
`ifdef NIC_SLAVE_MEM_CLEAR_EN
            clr_addr_q <= clr_addr_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        addr_q  <= addr_d;
        wr_q    <= wr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    // Memory is never reset; writes are blocked while reset is asserted.
    always_ff @(posedge i_clk) begin
`ifdef NIC_SLAVE_MEM_CLEAR_EN
        if (clr_we && !i_reset) mem[clr_addr_q] <= '0;
        else
`endif
        if (acc_en && acc_wr && !i_reset) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (acc_wstrb[b]) mem[acc_addr][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = rdata_q;
    assign o_ack   = (state_q == S_ACK);
    assign o_busy  = (state_q != S_IDLE);
endmodule
